// File: rtl/sb_io_if.sv
// Fabric-side signal bundle of one sb_io_cell. The fabric logic uses the master
// modport, the cell uses the slave modport.
interface sb_io_if;
  logic CLOCK_ENABLE;
  logic LATCH_INPUT_VALUE;
  logic OUTPUT_ENABLE;
  logic D_OUT_0;
  logic D_OUT_1;
  logic D_IN_0;
  logic D_IN_1;

  modport master (
    output CLOCK_ENABLE,
    output LATCH_INPUT_VALUE,
    output OUTPUT_ENABLE,
    output D_OUT_0,
    output D_OUT_1,
    input  D_IN_0,
    input  D_IN_1
  );

  modport slave (
    input  CLOCK_ENABLE,
    input  LATCH_INPUT_VALUE,
    input  OUTPUT_ENABLE,
    input  D_OUT_0,
    input  D_OUT_1,
    output D_IN_0,
    output D_IN_1
  );
endinterface : sb_io_if

// File: rtl/sb_io_cell.sv
// Single-bit bidirectional I/O cell, behaviourally equivalent to an iCE40 SB_IO:
// combinational / registered / latched / DDR input and output paths plus tri-state.
module sb_io_cell #(
  parameter logic [5:0] PIN_TYPE    = 6'b000000,
  parameter bit         PULLUP      = 1'b0,
  parameter bit         NEG_TRIGGER = 1'b0
) (
  input  logic   INPUT_CLK,
  input  logic   RESET_N,
  inout  wire    PACKAGE_PIN,
  sb_io_if.slave fabric
);

  typedef enum logic [1:0] {
    IN_REG        = 2'b00,
    IN_COMB       = 2'b01,
    IN_REG_LATCH  = 2'b10,
    IN_COMB_LATCH = 2'b11
  } in_mode_e;

  typedef enum logic [1:0] {
    OUT_DDR      = 2'b00,
    OUT_REG      = 2'b01,
    OUT_COMB     = 2'b10,
    OUT_REG_INV  = 2'b11
  } out_mode_e;

  typedef enum logic [1:0] {
    OE_NEVER  = 2'b00,
    OE_ALWAYS = 2'b01,
    OE_COMB   = 2'b10,
    OE_REG    = 2'b11
  } oe_mode_e;

  localparam in_mode_e  IN_MODE  = in_mode_e'(PIN_TYPE[1:0]);
  localparam out_mode_e OUT_MODE = out_mode_e'(PIN_TYPE[3:2]);
  localparam oe_mode_e  OE_MODE  = oe_mode_e'(PIN_TYPE[5:4]);

  // The weak pull lives on the pin net itself, so an undriven pin reads 1.
  if (PULLUP) begin : g_pullup
    pullup u_pullup (PACKAGE_PIN);
  end

  logic pin_val;
  assign pin_val = PACKAGE_PIN;

  // With NEG_TRIGGER every edge and every phase swaps, so one derived clock covers it.
  logic cap_clk;
  assign cap_clk = INPUT_CLK ^ NEG_TRIGGER;

  logic in0_q,  in0_d;
  logic in1_q,  in1_d;
  logic out0_q, out0_d;
  logic out1_q, out1_d;
  logic oe_q,   oe_d;
  logic lat_q;

  logic din0;
  logic pin_data;
  logic pin_oe;

  // NOTE: every variable gets a default first so no path through the block can infer a latch.
  always_comb begin
    in0_d  = in0_q;
    out0_d = out0_q;
    oe_d   = oe_q;
    if (fabric.CLOCK_ENABLE) begin
      out0_d = fabric.D_OUT_0;
      oe_d   = fabric.OUTPUT_ENABLE;
      if (!(IN_MODE == IN_REG_LATCH && fabric.LATCH_INPUT_VALUE)) begin
        in0_d = pin_val;
      end
    end
  end

  always_comb begin
    in1_d  = in1_q;
    out1_d = out1_q;
    if (fabric.CLOCK_ENABLE) begin
      in1_d  = pin_val;
      out1_d = fabric.D_OUT_1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge cap_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      in0_q  <= 1'b0;
      out0_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      in0_q  <= in0_d;
      out0_q <= out0_d;
      oe_q   <= oe_d;
    end
  end

  always_ff @(negedge cap_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      in1_q  <= 1'b0;
      out1_q <= 1'b0;
    end else begin
      in1_q  <= in1_d;
      out1_q <= out1_d;
    end
  end

  // NOTE: this is an intentional level-sensitive latch: transparent while LATCH_INPUT_VALUE is low.
  always_latch begin
    if (!RESET_N) begin
      lat_q <= 1'b0;
    end else if (!fabric.LATCH_INPUT_VALUE) begin
      lat_q <= pin_val;
    end
  end

  always_comb begin
    din0 = in0_q;
    unique case (IN_MODE)
      IN_REG, IN_REG_LATCH: din0 = in0_q;
      IN_COMB:              din0 = pin_val;
      IN_COMB_LATCH:        din0 = fabric.LATCH_INPUT_VALUE ? lat_q : pin_val;
    endcase
  end

  always_comb begin
    pin_data = 1'b0;
    unique case (OUT_MODE)
      OUT_DDR:     pin_data = cap_clk ? out0_q : out1_q;
      OUT_REG:     pin_data = out0_q;
      OUT_COMB:    pin_data = fabric.D_OUT_0;
      OUT_REG_INV: pin_data = ~out0_q;
    endcase
  end

  always_comb begin
    pin_oe = 1'b0;
    unique case (OE_MODE)
      OE_NEVER:  pin_oe = 1'b0;
      OE_ALWAYS: pin_oe = 1'b1;
      OE_COMB:   pin_oe = fabric.OUTPUT_ENABLE;
      OE_REG:    pin_oe = oe_q;
    endcase
  end

  assign PACKAGE_PIN   = pin_oe ? pin_data : 1'bz;
  assign fabric.D_IN_0 = din0;
  assign fabric.D_IN_1 = in1_q;

endmodule : sb_io_cell

// File: tb/tb_sb_io_cell.sv
// Randomized bench for sb_io_cell: ten cells with different configurations share one
// stimulus stream and are compared against a mode-table reference model.
module tb_sb_io_cell;

  localparam int NI      = 10;
  localparam int NCYC    = 400;
  localparam int DDR_IDX = 2;

  // Instance 0 sits in the low bits.
  localparam logic [NI*6-1:0] PT_ALL = {
    6'b010100, 6'b000001, 6'b011100, 6'b000001, 6'b000010,
    6'b000011, 6'b110100, 6'b010000, 6'b010100, 6'b101001
  };
  localparam logic [NI-1:0] PU_ALL  = 10'b0001001000;
  localparam logic [NI-1:0] NEG_ALL = 10'b1000000000;

  // Expected pin-level value; E_FLOAT means nobody drives the net.
  typedef enum logic [1:0] {E_0 = 2'd0, E_1 = 2'd1, E_FLOAT = 2'd2} lv_e;

  logic clk = 1'b0;
  logic rst_n, ce, liv, dout0, dout1, oe_in;
  logic [NI-1:0] drv_en, drv_val;
  wire  [NI-1:0] din0, din1, pin_rd;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    wire pin;
    sb_io_if ifc ();

    assign pin                   = drv_en[gi] ? drv_val[gi] : 1'bz;
    assign ifc.CLOCK_ENABLE      = ce;
    assign ifc.LATCH_INPUT_VALUE = liv;
    assign ifc.OUTPUT_ENABLE     = oe_in;
    assign ifc.D_OUT_0           = dout0;
    assign ifc.D_OUT_1           = dout1;
    assign din0[gi]              = ifc.D_IN_0;
    assign din1[gi]              = ifc.D_IN_1;
    assign pin_rd[gi]            = pin;

    sb_io_cell #(
      .PIN_TYPE    (PT_ALL[gi*6 +: 6]),
      .PULLUP      (PU_ALL[gi]),
      .NEG_TRIGGER (NEG_ALL[gi])
    ) u_dut (
      .INPUT_CLK   (clk),
      .RESET_N     (rst_n),
      .PACKAGE_PIN (pin),
      .fabric      (ifc.slave)
    );
  end

  // Reference model: what each cell last captured, per instance.
  bit  m_out0 [NI];
  bit  m_out1 [NI];
  bit  m_oe   [NI];
  lv_e m_in0  [NI];
  lv_e m_in1  [NI];
  lv_e m_lat  [NI];

  task automatic check(string tag, logic obs, lv_e exp);
    logic bad;
    n_checks++;
    if (exp == E_FLOAT) bad = (obs === 1'b1);
    else                bad = (obs !== exp[0]);
    if (bad) begin
      n_errors++;
      $display("FAIL %s: observed %b expected %s", tag, obs, exp.name());
    end
  endtask

  function automatic lv_e to_lv(logic b);
    return b ? E_1 : E_0;
  endfunction

  // Pin level seen by everyone, given the clock phase as the cell sees it.
  function automatic lv_e exp_pin(int i, logic ph);
    logic [5:0] pt;
    logic       drv, dat;
    pt = PT_ALL[i*6 +: 6];
    case (pt[5:4])
      2'b00:   drv = 1'b0;
      2'b01:   drv = 1'b1;
      2'b10:   drv = oe_in;
      default: drv = m_oe[i];
    endcase
    case (pt[3:2])
      2'b00:   dat = ph ? m_out0[i] : m_out1[i];
      2'b01:   dat = m_out0[i];
      2'b10:   dat = dout0;
      default: dat = ~m_out0[i];
    endcase
    if (drv)        return to_lv(dat);
    if (drv_en[i])  return to_lv(drv_val[i]);
    if (PU_ALL[i])  return E_1;
    return E_FLOAT;
  endfunction

  function automatic lv_e exp_din0(int i, lv_e pv);
    case (PT_ALL[i*6 +: 2])
      2'b01:   return pv;
      2'b11:   return liv ? m_lat[i] : pv;
      default: return m_in0[i];
    endcase
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NI; i++) begin
      m_out0[i] = 1'b0; m_out1[i] = 1'b0; m_oe[i] = 1'b0;
      m_in0[i]  = E_0;  m_in1[i]  = E_0;  m_lat[i] = E_0;
    end
  endtask

  task automatic track_latch();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n)   m_lat[i] = E_0;
      else if (!liv) m_lat[i] = exp_pin(i, clk ^ NEG_ALL[i]);
    end
  endtask

  // Apply one clock edge to the model; the pin is evaluated as it was just before the edge.
  task automatic model_edge(bit rising);
    for (int i = 0; i < NI; i++) begin
      lv_e pv;
      bit  act_rise;
      pv       = exp_pin(i, (!rising) ^ NEG_ALL[i]);
      act_rise = rising ^ NEG_ALL[i];
      if (rst_n && ce) begin
        if (act_rise) begin
          if (!(PT_ALL[i*6 +: 2] == 2'b10 && liv)) m_in0[i] = pv;
          m_out0[i] = dout0;
          m_oe[i]   = oe_in;
        end else begin
          m_in1[i]  = pv;
          m_out1[i] = dout1;
        end
      end
    end
    track_latch();
  endtask

  task automatic check_all(string when);
    for (int i = 0; i < NI; i++) begin
      lv_e pv;
      pv = exp_pin(i, clk ^ NEG_ALL[i]);
      check($sformatf("%s u%0d pin", when, i), pin_rd[i], pv);
      if (i != DDR_IDX) begin
        check($sformatf("%s u%0d din0", when, i), din0[i], exp_din0(i, pv));
        check($sformatf("%s u%0d din1", when, i), din1[i], m_in1[i]);
      end
    end
  endtask

  task automatic new_drive();
    ce      = ($urandom_range(0, 99) < 75);
    dout0   = 1'($urandom_range(0, 1));
    dout1   = 1'($urandom_range(0, 1));
    oe_in   = 1'($urandom_range(0, 1));
    drv_val = NI'($urandom);
    drv_en  = '0;
    drv_en[0] = !oe_in;
    drv_en[4] = 1'b1;
    drv_en[5] = 1'b1;
    drv_en[6] = 1'($urandom_range(0, 1));
    drv_en[8] = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n = 1'b0;
    liv   = 1'b0;
    ce    = 1'b0;
    dout0 = 1'b0;
    dout1 = 1'b0;
    oe_in = 1'b0;
    drv_val = '0;
    drv_en  = '0;
    drv_en[0] = 1'b1;
    drv_en[4] = 1'b1;
    drv_en[5] = 1'b1;
    reset_model();
    #1 check_all("init");

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      model_edge(1'b1);
      #1 check_all("rise");

      if (cyc < 2)         rst_n = 1'b0;
      else if (cyc == 2)   rst_n = 1'b1;
      else if (!rst_n)     rst_n = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 99) < 3) rst_n = 1'b0;
      if (!rst_n) reset_model();
      track_latch();
      #1 check_all("rst");

      liv = ($urandom_range(0, 99) < 30);
      #1 track_latch();
      check_all("liv");

      new_drive();
      #1 track_latch();
      check_all("drv");

      @(negedge clk);
      model_edge(1'b0);
      #1 check_all("fall");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sb_io_cell
